program_loader: RTL and testbench

- Writer side of the BIP program memory.
- Takes a byte stream from the UART receiver, packs byte pairs into 16-bit instruction words and writes them to sequential program-memory addresses starting at 0.
- Stops at the HALT word (0x0000) or when memory is full, then asserts `done` so the top level can release the CPU.

---
 rtl/program_loader_if.sv | 45 ++++
 rtl/program_loader.sv | 177 +++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader_if                                            |
// | Description : Bus bundle between the UART byte source, the program        |
// |               loader and the program-memory write port.                   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
// Signals:
//   start       loader <- host : one-cycle pulse, (re)start a load at address 0
//   rx_valid    loader <- UART : one-cycle pulse, rx_data holds a new byte
//   rx_data     loader <- UART : received byte
//   wr_en       loader -> mem  : one-cycle write strobe
//   wr_addr     loader -> mem  : write address, valid with wr_en
//   wr_data     loader -> mem  : instruction word, valid with wr_en
//   busy        loader -> host : load in progress
//   done        loader -> host : load finished, sticky until start/reset
//   word_count  loader -> host : words written in the current/last load
//   chk_err     loader -> host : sticky checksum mismatch
// Modports: master = loader side, slave = environment side.
interface program_loader_if #(
  parameter int LEN_ADDR = 11,
  parameter int LEN_DATA = 16
);
  logic                start;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                wr_en;
  logic [LEN_ADDR-1:0] wr_addr;
  logic [LEN_DATA-1:0] wr_data;
  logic                busy;
  logic                done;
  logic [LEN_ADDR:0]   word_count;
  logic                chk_err;

  modport master (
    input  start, rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, busy, done, word_count, chk_err
  );

  modport slave (
    output start, rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, busy, done, word_count, chk_err
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader                                               |
// | Description : Packs a UART byte stream into 16-bit instruction words and  |
// |               writes them to program memory from address 0 until a HALT   |
// |               word (0x0000) or the last address, then raises done.        |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
// Ports:
//   clk       in  system clock, all logic on posedge
//   reset_n   in  synchronous active-low reset
//   bus       program_loader_if.master (start/rx in, memory write + status out)
// Parameters:
//   LEN_ADDR  program-memory address width
//   LEN_DATA  instruction width (two bytes per word, fixed at 16)
//   RAM_DEPTH number of program-memory words
// Optional build macro:
//   LOADER_CHECKSUM_EN - after the terminating write, one extra byte is
//   compared with the XOR of all data bytes; a mismatch sets chk_err.
module program_loader #(
  parameter int LEN_ADDR  = 11,
  parameter int LEN_DATA  = 16,
  parameter int RAM_DEPTH = 2048
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  program_loader_if.master   bus
);

  localparam logic [LEN_ADDR-1:0] c_last_addr = LEN_ADDR'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_HI = 3'd1,
    S_WAIT_LO = 3'd2,
    S_DONE    = 3'd3
`ifdef LOADER_CHECKSUM_EN
    , S_WAIT_CK = 3'd4
`endif
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [LEN_ADDR-1:0] r_addr,       w_addr_nxt;
  logic [7:0]          r_hi,         w_hi_nxt;
  logic                r_wr_en,      w_wr_en_nxt;
  logic [LEN_ADDR-1:0] r_wr_addr,    w_wr_addr_nxt;
  logic [LEN_DATA-1:0] r_wr_data,    w_wr_data_nxt;
  logic                r_busy,       w_busy_nxt;
  logic                r_done,       w_done_nxt;
  logic [LEN_ADDR:0]   r_word_count, w_word_count_nxt;
  logic                w_last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_xor,        w_xor_nxt;
  logic                r_chk_err,    w_chk_err_nxt;
`endif

  // Current pair terminates the load: HALT word or last writable address.
  assign w_last_word = ((r_hi == 8'h00) && (bus.rx_data == 8'h00)) ||
                       (r_addr == c_last_addr);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_hi         <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= '0;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_hi         <= w_hi_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_word_count <= w_word_count_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= w_xor_nxt;
      r_chk_err    <= w_chk_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_hi_nxt         = r_hi;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_word_count_nxt = r_word_count;
`ifdef LOADER_CHECKSUM_EN
    w_xor_nxt        = r_xor;
    w_chk_err_nxt    = r_chk_err;
`endif

    // start wins over everything, including a byte arriving in the same cycle.
    if (bus.start) begin
      w_state_nxt      = S_WAIT_HI;
      w_addr_nxt       = '0;
      w_busy_nxt       = 1'b1;
      w_done_nxt       = 1'b0;
      w_word_count_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
      w_xor_nxt        = '0;
      w_chk_err_nxt    = 1'b0;
`endif
    end else if (bus.rx_valid) begin
      case (r_state)
        S_WAIT_HI: begin
          w_hi_nxt    = bus.rx_data;
          w_state_nxt = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
          w_xor_nxt   = r_xor ^ bus.rx_data;
`endif
        end
        S_WAIT_LO: begin
          w_wr_en_nxt      = 1'b1;
          w_wr_addr_nxt    = r_addr;
          w_wr_data_nxt    = {r_hi, bus.rx_data};
          w_word_count_nxt = r_word_count + (LEN_ADDR+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          w_xor_nxt        = r_xor ^ bus.rx_data;
`endif
          if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = S_WAIT_CK;
`else
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
`endif
          end else begin
            w_addr_nxt  = r_addr + LEN_ADDR'(1);
            w_state_nxt = S_WAIT_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_WAIT_CK: begin
          w_chk_err_nxt = (bus.rx_data != r_xor);
          w_state_nxt   = S_DONE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
        end
`endif
        default: begin
          // IDLE and DONE ignore incoming bytes.
        end
      endcase
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.word_count = r_word_count;
`ifdef LOADER_CHECKSUM_EN
  assign bus.chk_err    = r_chk_err;
`else
  assign bus.chk_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_program_loader                                            |
// | Description : Directed self-checking bench for program_loader; a default  |
// |               instance (2048 words) and a 4-word instance share stimulus. |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tb_start;
  logic       tb_rx_valid;
  logic [7:0] tb_rx_data;

  int n_cmp = 0;
  int n_err = 0;

  program_loader_if #(.LEN_ADDR(11), .LEN_DATA(16)) bus_a ();
  program_loader_if #(.LEN_ADDR(2),  .LEN_DATA(16)) bus_b ();

  assign bus_a.start    = tb_start;
  assign bus_a.rx_valid = tb_rx_valid;
  assign bus_a.rx_data  = tb_rx_data;
  assign bus_b.start    = tb_start;
  assign bus_b.rx_valid = tb_rx_valid;
  assign bus_b.rx_data  = tb_rx_data;

  program_loader #(.LEN_ADDR(11), .LEN_DATA(16), .RAM_DEPTH(2048)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  program_loader #(.LEN_ADDR(2), .LEN_DATA(16), .RAM_DEPTH(4)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  // Write logs and wr_en width monitors, sampled on the falling edge.
  logic [31:0] log_a_addr[$];
  logic [31:0] log_a_data[$];
  logic [31:0] log_b_addr[$];
  logic [31:0] log_b_data[$];
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  int          wide_cnt = 0;

  always @(negedge clk) begin
    if (bus_a.wr_en === 1'b1) begin
      log_a_addr.push_back(32'(bus_a.wr_addr));
      log_a_data.push_back(32'(bus_a.wr_data));
    end
    if (bus_b.wr_en === 1'b1) begin
      log_b_addr.push_back(32'(bus_b.wr_addr));
      log_b_data.push_back(32'(bus_b.wr_data));
    end
    if ((prev_a && bus_a.wr_en === 1'b1) || (prev_b && bus_b.wr_en === 1'b1))
      wide_cnt <= wide_cnt + 1;
    prev_a <= (bus_a.wr_en === 1'b1);
    prev_b <= (bus_b.wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tb_rx_valid = 1'b1;
    tb_rx_data  = b;
    @(negedge clk);
    tb_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
  endtask

  task automatic check_wr_a(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    check({tag, "_addr"}, (idx < log_a_addr.size()) ? log_a_addr[idx] : 32'hDEAD_BEEF, ea);
    check({tag, "_data"}, (idx < log_a_data.size()) ? log_a_data[idx] : 32'hDEAD_BEEF, ed);
  endtask

  task automatic check_wr_b(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    check({tag, "_addr"}, (idx < log_b_addr.size()) ? log_b_addr[idx] : 32'hDEAD_BEEF, ea);
    check({tag, "_data"}, (idx < log_b_data.size()) ? log_b_data[idx] : 32'hDEAD_BEEF, ed);
  endtask

  initial begin
    int base;
    reset_n     = 1'b0;
    tb_start    = 1'b0;
    tb_rx_valid = 1'b0;
    tb_rx_data  = 8'h00;

    // Reset held over start/rx activity.
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0; tb_rx_valid = 1'b1; tb_rx_data = 8'h12;
    @(negedge clk); tb_rx_data = 8'h34;
    @(negedge clk); tb_rx_valid = 1'b0; reset_n = 1'b1;
    settle();
    check("rst_wr_en",  32'(bus_a.wr_en), 0);
    check("rst_busy",   32'(bus_a.busy), 0);
    check("rst_done",   32'(bus_a.done), 0);
    check("rst_count",  32'(bus_a.word_count), 0);
    check("rst_chk",    32'(bus_a.chk_err), 0);
    check("rst_waddr",  32'(bus_a.wr_addr), 0);
    check("rst_wdata",  32'(bus_a.wr_data), 0);
    check("rst_writes", 32'(log_a_addr.size()), 0);

    // Bytes in IDLE are ignored.
    send_byte(8'h12); send_byte(8'h34);
    settle();
    check("idle_writes", 32'(log_a_addr.size()), 0);
    check("idle_count",  32'(bus_a.word_count), 0);
    check("idle_busy",   32'(bus_a.busy), 0);

    // Normal load.
    pulse_start();
    #1;
    check("start_busy", 32'(bus_a.busy), 1);
    check("start_done", 32'(bus_a.done), 0);
    send_byte(8'h08); send_byte(8'h05);
    send_byte(8'h10); send_byte(8'h07);
    send_byte(8'h00); send_byte(8'h00);
    settle();
`ifdef LOADER_CHECKSUM_EN
    check("load_ck_busy", 32'(bus_a.busy), 1);
    check("load_ck_done", 32'(bus_a.done), 0);
    send_byte(8'h1A);
    settle();
`endif
    check("load_writes", 32'(log_a_addr.size()), 3);
    check_wr_a("load_w0", 0, 32'h0, 32'h0805);
    check_wr_a("load_w1", 1, 32'h1, 32'h1007);
    check_wr_a("load_w2", 2, 32'h2, 32'h0000);
    check("load_done",  32'(bus_a.done), 1);
    check("load_busy",  32'(bus_a.busy), 0);
    check("load_count", 32'(bus_a.word_count), 3);
    check("load_chk",   32'(bus_a.chk_err), 0);
    check("load_wide",  32'(wide_cnt), 0);

    // Bytes in DONE are ignored; write port holds its last values.
    send_byte(8'h12); send_byte(8'h34);
    settle();
    check("done_writes", 32'(log_a_addr.size()), 3);
    check("done_count",  32'(bus_a.word_count), 3);
    check("done_hold",   32'(bus_a.done), 1);
    check("done_waddr",  32'(bus_a.wr_addr), 2);
    check("done_wr_en",  32'(bus_a.wr_en), 0);

    // Restart mid-load drops the pending high byte.
    base = log_a_addr.size();
    pulse_start();
    send_byte(8'hAB);
    pulse_start();
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h26);
`endif
    settle();
    check("rstrt_writes", 32'(log_a_addr.size() - base), 2);
    check_wr_a("rstrt_w0", base,     32'h0, 32'h1234);
    check_wr_a("rstrt_w1", base + 1, 32'h1, 32'h0000);
    check("rstrt_count", 32'(bus_a.word_count), 2);
    check("rstrt_done",  32'(bus_a.done), 1);

    // Reset between high and low byte produces no write.
    base = log_a_addr.size();
    pulse_start();
    send_byte(8'h55);
    @(negedge clk); reset_n = 1'b0; tb_rx_valid = 1'b1; tb_rx_data = 8'h66;
    @(negedge clk); tb_rx_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    settle();
    check("mrst_writes", 32'(log_a_addr.size() - base), 0);
    check("mrst_busy",   32'(bus_a.busy), 0);
    check("mrst_count",  32'(bus_a.word_count), 0);

    // Full memory on the 4-word instance.
    base = log_b_addr.size();
    pulse_start();
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h44);
    settle();
`ifdef LOADER_CHECKSUM_EN
    check("full_ck_busy", 32'(bus_b.busy), 1);
    send_byte(8'h00);
    settle();
`endif
    check("full_done_4th", 32'(bus_b.done), 1);
    send_byte(8'h55); send_byte(8'h55);
    settle();
    check("full_writes", 32'(log_b_addr.size() - base), 4);
    check_wr_b("full_w0", base,     32'h0, 32'h1111);
    check_wr_b("full_w1", base + 1, 32'h1, 32'h2222);
    check_wr_b("full_w2", base + 2, 32'h2, 32'h3333);
    check_wr_b("full_w3", base + 3, 32'h3, 32'h4444);
    check("full_count", 32'(bus_b.word_count), 4);
    check("full_busy",  32'(bus_b.busy), 0);
    check("full_chk",   32'(bus_b.chk_err), 0);

    // Checksum match, then mismatch.
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00);
    settle();
`ifdef LOADER_CHECKSUM_EN
    check("ck1_wait_done", 32'(bus_a.done), 0);
    send_byte(8'h03);
    settle();
`endif
    check("ck1_done",  32'(bus_a.done), 1);
    check("ck1_chk",   32'(bus_a.chk_err), 0);
    check("ck1_count", 32'(bus_a.word_count), 2);
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h04);
    settle();
    check("ck2_done", 32'(bus_a.done), 1);
`ifdef LOADER_CHECKSUM_EN
    check("ck2_chk", 32'(bus_a.chk_err), 1);
`else
    check("ck2_chk", 32'(bus_a.chk_err), 0);
`endif
    check("final_wide", 32'(wide_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
